// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage: slices register addresses out of the RV32I
// word, bypasses a same-cycle writeback, interlocks on outstanding writers via
// a per-register busy scoreboard and hands operands to execute through a
// single valid/ready output slot.
module operand_fetch #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_addr1,
    output logic [4:0]      rf_addr2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busy_next;
    logic [31:0]          busy_all;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_any;
    logic            writes_rd;
    logic            wb_hit1;
    logic            wb_hit2;
    logic            wb_hitd;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];
    assign rd       = in_instr[11:7];
    assign rf_addr1 = rs1;
    assign rf_addr2 = rs2;

    // Opcode decode: which sources are read and whether rd is written
    always_comb begin
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        writes_any = 1'b0;
        case (in_instr[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: writes_any = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                uses_rs1   = 1'b1;
                writes_any = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                writes_any = 1'b1;
            end
            default: ;
        endcase
        writes_rd = writes_any && (rd != 5'd0);
    end

    // Zero-extended scoreboard view so any 5-bit address indexes safely
    always_comb begin
        busy_all                = '0;
        busy_all[REG_COUNT-1:0] = busy;
    end

    // Bypass selection, hazard detection and input handshake
    always_comb begin
        wb_hit1 = wb_en && (wb_addr == rs1);
        wb_hit2 = wb_en && (wb_addr == rs2);
        wb_hitd = wb_en && (wb_addr == rd);

        if (rs1 == 5'd0)  op1 = '0;
        else if (wb_hit1) op1 = wb_data;
        else              op1 = rf_data1;

        if (rs2 == 5'd0)  op2 = '0;
        else if (wb_hit2) op2 = wb_data;
        else              op2 = rf_data2;

        hazard = (uses_rs1 && (rs1 != 5'd0) && busy_all[rs1] && !wb_hit1) ||
                 (uses_rs2 && (rs2 != 5'd0) && busy_all[rs2] && !wb_hit2) ||
                 (writes_rd && busy_all[rd] && !wb_hitd);

        in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    // Scoreboard update: clears from writeback or flush, set from accept wins
    always_comb begin
        busy_next = busy;
        for (int unsigned i = 1; i < REG_COUNT; i++) begin
            if (wb_en && (wb_addr == 5'(i)))
                busy_next[i] = 1'b0;
            if (flush && out_valid && (out_rd == 5'(i)))
                busy_next[i] = 1'b0;
            if (accept && writes_rd && (rd == 5'(i)))
                busy_next[i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    // Output slot: load on accept, drain on handshake, kill on flush
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_instr    <= in_instr;
            out_pc       <= in_pc;
            out_rs1_data <= op1;
            out_rs2_data <= op2;
            out_rd       <= writes_rd ? rd : 5'd0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch: each record is one clock
// cycle of stimulus with hand-computed handshake, slot and scoreboard values.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_addr1;
    logic [4:0]  rf_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] D1 = 32'hAAAA_0001;
    localparam logic [31:0] D2 = 32'hBBBB_0002;

    operand_fetch #(.XLEN(32), .REG_COUNT(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rf_addr1     (rf_addr1),
        .rf_addr2     (rf_addr2),
        .rf_data1     (rf_data1),
        .rf_data2     (rf_data2),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rd       (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic [4:0]  e_a1;
        logic [4:0]  e_a2;
        logic        e_ov;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [4:0]  e_rd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check comb outputs, then registered state after the edge
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        rst       = v.rst;
        in_valid  = v.iv;
        in_instr  = v.instr;
        in_pc     = v.pc;
        rf_data1  = v.d1;
        rf_data2  = v.d2;
        wb_en     = v.wbe;
        wb_addr   = v.wba;
        wb_data   = v.wbd;
        flush     = v.fl;
        out_ready = v.ordy;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(v.e_ir));
        chk({tag, " rf_addr1"}, 32'(rf_addr1), 32'(v.e_a1));
        chk({tag, " rf_addr2"}, 32'(rf_addr2), 32'(v.e_a2));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
        chk({tag, " out_instr"}, out_instr, v.e_instr);
        chk({tag, " out_pc"}, out_pc, v.e_pc);
        chk({tag, " out_rs1_data"}, out_rs1_data, v.e_rs1);
        chk({tag, " out_rs2_data"}, out_rs2_data, v.e_rs2);
        chk({tag, " out_rd"}, 32'(out_rd), 32'(v.e_rd));
        chk({tag, " busy"}, dut.busy, v.e_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        rf_data1 = D1; rf_data2 = D2; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        //          rst  iv   instr         pc      d1            d2  wbe  wba    wbd            fl   ordy | ir  a1     a2     ov   instr         pc      rs1           rs2           rd     busy
        tbl[0]  = '{1'b1,1'b1,32'h0050_0093,32'h100,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b0,5'd0, 5'd5, 1'b0,32'h0,         32'h0,  32'h0,        32'h0,        5'd0,  32'h000};
        tbl[1]  = '{1'b0,1'b1,32'h0050_0093,32'h100,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b1,5'd0, 5'd5, 1'b1,32'h0050_0093,32'h100,32'h0,        D2,           5'd1,  32'h002};
        tbl[2]  = '{1'b0,1'b1,32'h0010_8133,32'h104,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b0,5'd1, 5'd1, 1'b0,32'h0050_0093,32'h100,32'h0,        D2,           5'd1,  32'h002};
        tbl[3]  = '{1'b0,1'b1,32'h0010_8133,32'h104,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b0,5'd1, 5'd1, 1'b0,32'h0050_0093,32'h100,32'h0,        D2,           5'd1,  32'h002};
        tbl[4]  = '{1'b0,1'b1,32'h0010_8133,32'h104,D1,           D2,1'b1,5'd1, 32'h5,         1'b0,1'b1, 1'b1,5'd1, 5'd1, 1'b1,32'h0010_8133,32'h104,32'h5,        32'h5,        5'd2,  32'h004};
        tbl[5]  = '{1'b0,1'b0,32'h0,        32'h0,  D1,           D2,1'b1,5'd2, 32'h22,        1'b0,1'b1, 1'b1,5'd0, 5'd0, 1'b0,32'h0010_8133,32'h104,32'h5,        32'h5,        5'd2,  32'h000};
        tbl[6]  = '{1'b0,1'b1,32'h0000_2183,32'h108,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b0, 1'b1,5'd0, 5'd0, 1'b1,32'h0000_2183,32'h108,32'h0,        32'h0,        5'd3,  32'h008};
        tbl[7]  = '{1'b0,1'b1,32'h0001_8233,32'h10C,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b0, 1'b0,5'd3, 5'd0, 1'b1,32'h0000_2183,32'h108,32'h0,        32'h0,        5'd3,  32'h008};
        tbl[8]  = '{1'b0,1'b1,32'h0001_8233,32'h10C,D1,           D2,1'b0,5'd0, 32'h0,         1'b1,1'b0, 1'b0,5'd3, 5'd0, 1'b0,32'h0000_2183,32'h108,32'h0,        32'h0,        5'd3,  32'h000};
        tbl[9]  = '{1'b0,1'b1,32'h0001_8233,32'h10C,32'h3333_3333,D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b1,5'd3, 5'd0, 1'b1,32'h0001_8233,32'h10C,32'h3333_3333,32'h0,        5'd4,  32'h010};
        tbl[10] = '{1'b0,1'b1,32'h0070_0293,32'h110,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b1,5'd0, 5'd7, 1'b1,32'h0070_0293,32'h110,32'h0,        D2,           5'd5,  32'h030};
        tbl[11] = '{1'b0,1'b1,32'h0012_8293,32'h114,D1,           D2,1'b1,5'd5, 32'h55,        1'b0,1'b1, 1'b1,5'd5, 5'd1, 1'b1,32'h0012_8293,32'h114,32'h55,       D2,           5'd5,  32'h030};
        tbl[12] = '{1'b0,1'b1,32'h0000_0333,32'h118,D1,           D2,1'b1,5'd0, 32'hDEAD,      1'b0,1'b1, 1'b1,5'd0, 5'd0, 1'b1,32'h0000_0333,32'h118,32'h0,        32'h0,        5'd6,  32'h070};
        tbl[13] = '{1'b0,1'b1,32'h0002_03B7,32'h11C,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b1,5'd4, 5'd0, 1'b1,32'h0002_03B7,32'h11C,D1,           32'h0,        5'd7,  32'h0F0};
        tbl[14] = '{1'b0,1'b1,32'h0070_A023,32'h120,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b0,5'd1, 5'd7, 1'b0,32'h0002_03B7,32'h11C,D1,           32'h0,        5'd7,  32'h0F0};
        tbl[15] = '{1'b0,1'b1,32'h0070_A023,32'h120,D1,           D2,1'b1,5'd7, 32'h77,        1'b0,1'b1, 1'b1,5'd1, 5'd7, 1'b1,32'h0070_A023,32'h120,D1,           32'h77,       5'd0,  32'h070};
        tbl[16] = '{1'b0,1'b1,32'h0010_0313,32'h124,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b0,5'd0, 5'd1, 1'b0,32'h0070_A023,32'h120,D1,           32'h77,       5'd0,  32'h070};
        tbl[17] = '{1'b0,1'b1,32'h0062_837F,32'h124,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b1,5'd5, 5'd6, 1'b1,32'h0062_837F,32'h124,D1,           D2,           5'd0,  32'h070};
        tbl[18] = '{1'b0,1'b1,32'h0000_0013,32'h128,D1,           D2,1'b0,5'd0, 32'h0,         1'b0,1'b1, 1'b1,5'd0, 5'd0, 1'b1,32'h0000_0013,32'h128,32'h0,        32'h0,        5'd0,  32'h070};
        tbl[19] = '{1'b0,1'b0,32'h0,        32'h0,  D1,           D2,1'b1,5'd4, 32'h44,        1'b0,1'b1, 1'b1,5'd0, 5'd0, 1'b0,32'h0000_0013,32'h128,32'h0,        32'h0,        5'd0,  32'h060};

        for (int i = 0; i < 20; i++)
            run_vec(tbl[i], $sformatf("row%0d", i));

        // Back-pressure: accept into a stalled slot, hold 3 cycles, then release
        v = '{1'b0,1'b1,32'h0050_0093,32'h200,D1,D2,1'b0,5'd0,32'h0,1'b0,1'b0,
              1'b1,5'd0,5'd5,1'b1,32'h0050_0093,32'h200,32'h0,D2,5'd1,32'h062};
        run_vec(v, "hold_load");
        for (int k = 0; k < 3; k++) begin
            v = '{1'b0,1'b1,32'h0030_0113,32'h204,D1,D2,1'b0,5'd0,32'h0,1'b0,1'b0,
                  1'b0,5'd0,5'd3,1'b1,32'h0050_0093,32'h200,32'h0,D2,5'd1,32'h062};
            run_vec(v, $sformatf("hold_stall%0d", k));
        end
        v = '{1'b0,1'b1,32'h0030_0113,32'h204,D1,D2,1'b0,5'd0,32'h0,1'b0,1'b1,
              1'b1,5'd0,5'd3,1'b1,32'h0030_0113,32'h204,32'h0,D2,5'd2,32'h066};
        run_vec(v, "hold_release");

        // Reset in the middle of operation with a live slot and busy[7]
        v = '{1'b0,1'b1,32'h0000_03B7,32'h208,D1,D2,1'b0,5'd0,32'h0,1'b0,1'b1,
              1'b1,5'd0,5'd0,1'b1,32'h0000_03B7,32'h208,32'h0,32'h0,5'd7,32'h0E6};
        run_vec(v, "pre_rst");
        v = '{1'b1,1'b1,32'h0000_03B7,32'h20C,D1,D2,1'b0,5'd0,32'h0,1'b0,1'b0,
              1'b0,5'd0,5'd0,1'b0,32'h0,32'h0,32'h0,32'h0,5'd0,32'h000};
        run_vec(v, "mid_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
